// File: rtl/spi_engine_sdo_lane_scheduler.sv
// SDO lane scheduler: scans the lane mask into an ordered list of active
// lanes, then steers each upstream word to the next active lane slot and
// holds off upstream until the shift register takes the completed set.
module spi_engine_sdo_lane_scheduler #(
  parameter int NUM_OF_SDO = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_valid,
  input  logic [7:0]            cfg_mask,
  output logic                  cfg_ready,
  input  logic                  s_data_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_data_ready,
  output logic                  lane_we,
  output logic [3:0]            lane_sel,
  output logic [DATA_WIDTH-1:0] lane_data,
  output logic                  set_ready,
  input  logic                  load_ack,
  output logic [3:0]            num_active,
  output logic                  busy
);

  // Lanes that physically exist; mask bits above them are always dropped.
  localparam logic [8:0] LANE_MASK_W = (9'd1 << NUM_OF_SDO) - 9'd1;
  localparam logic [7:0] LANE_MASK   = LANE_MASK_W[7:0];
  localparam logic [3:0] LAST_SCAN   = 4'(NUM_OF_SDO - 1);

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    FILL      = 2'd1,
    WAIT_LOAD = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            mask_q, mask_d;
  logic [3:0]            scan_idx_q, scan_idx_d;
  logic [3:0]            fill_idx_q, fill_idx_d;
  logic [3:0]            list_len_q, list_len_d;
  logic [3:0]            num_active_q, num_active_d;
  logic                  lane_we_q, lane_we_d;
  logic [3:0]            lane_sel_q, lane_sel_d;
  logic [DATA_WIDTH-1:0] lane_data_q, lane_data_d;
  logic                  set_ready_q, set_ready_d;

  // Ordered list of active physical lanes, built one entry per scan cycle.
  logic [3:0] active_list_q [8];
  logic       list_we;
  logic [2:0] list_waddr;
  logic [3:0] list_wdata;

  logic       bit_set;
  logic [3:0] scan_count;

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    scan_idx_d   = scan_idx_q;
    fill_idx_d   = fill_idx_q;
    list_len_d   = list_len_q;
    num_active_d = num_active_q;
    lane_we_d    = 1'b0;
    lane_sel_d   = lane_sel_q;
    lane_data_d  = lane_data_q;
    set_ready_d  = set_ready_q;
    list_we      = 1'b0;
    list_waddr   = 3'd0;
    list_wdata   = 4'd0;
    cfg_ready    = 1'b0;
    s_data_ready = 1'b0;
    bit_set      = mask_q[scan_idx_q[2:0]];
    scan_count   = list_len_q + {3'b000, bit_set};

    unique case (state_q)
      SCAN: begin
        if (bit_set) begin
          list_we    = 1'b1;
          list_waddr = list_len_q[2:0];
          list_wdata = scan_idx_q;
          list_len_d = list_len_q + 4'd1;
        end
        scan_idx_d = scan_idx_q + 4'd1;
        if (scan_idx_q == LAST_SCAN) begin
          // An empty mask falls back to lane 0 so there is always one lane.
          if (scan_count == 4'd0) begin
            list_we      = 1'b1;
            list_waddr   = 3'd0;
            list_wdata   = 4'd0;
            num_active_d = 4'd1;
          end else begin
            num_active_d = scan_count;
          end
          fill_idx_d = 4'd0;
          state_d    = FILL;
        end
      end

      FILL: begin
        // Reconfiguration only at a set boundary, and it beats data there.
        cfg_ready    = (fill_idx_q == 4'd0);
        s_data_ready = !(cfg_ready && cfg_valid);
        if (cfg_valid && cfg_ready) begin
          mask_d     = cfg_mask & LANE_MASK;
          scan_idx_d = 4'd0;
          list_len_d = 4'd0;
          state_d    = SCAN;
        end else if (s_data_valid) begin
          lane_we_d   = 1'b1;
          lane_sel_d  = active_list_q[fill_idx_q[2:0]];
          lane_data_d = s_data;
          if (fill_idx_q == num_active_q - 4'd1) begin
            fill_idx_d  = 4'd0;
            set_ready_d = 1'b1;
            state_d     = WAIT_LOAD;
          end else begin
            fill_idx_d = fill_idx_q + 4'd1;
          end
        end
      end

      WAIT_LOAD: begin
        if (load_ack) begin
          set_ready_d = 1'b0;
          state_d     = FILL;
        end
      end

      default: state_d = SCAN;
    endcase
  end

  // State and output registers; reset drops any partial set.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= SCAN;
      mask_q       <= LANE_MASK;
      scan_idx_q   <= 4'd0;
      fill_idx_q   <= 4'd0;
      list_len_q   <= 4'd0;
      num_active_q <= 4'd0;
      lane_we_q    <= 1'b0;
      lane_sel_q   <= 4'd0;
      lane_data_q  <= '0;
      set_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      scan_idx_q   <= scan_idx_d;
      fill_idx_q   <= fill_idx_d;
      list_len_q   <= list_len_d;
      num_active_q <= num_active_d;
      lane_we_q    <= lane_we_d;
      lane_sel_q   <= lane_sel_d;
      lane_data_q  <= lane_data_d;
      set_ready_q  <= set_ready_d;
    end
  end

  // Active-lane list storage; stale entries beyond num_active are never read.
  always_ff @(posedge clk) begin
    if (list_we) begin
      active_list_q[list_waddr] <= list_wdata;
    end
  end

  assign lane_we    = lane_we_q;
  assign lane_sel   = lane_sel_q;
  assign lane_data  = lane_data_q;
  assign set_ready  = set_ready_q;
  assign num_active = num_active_q;
  assign busy       = !(state_q == FILL && fill_idx_q == 4'd0);

endmodule

// File: tb/tb_spi_engine_sdo_lane_scheduler.sv
// Bench for the SDO lane scheduler: directed scenarios plus random traffic,
// checked cycle by cycle against a transaction-level model of the lane rules.
module tb_spi_engine_sdo_lane_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [7:0]    cfg_mask = 8'h00;
  logic          cfg_ready;
  logic          s_data_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_data_ready;
  logic          lane_we;
  logic [3:0]    lane_sel;
  logic [DW-1:0] lane_data;
  logic          set_ready;
  logic          load_ack = 1'b0;
  logic [3:0]    num_active;
  logic          busy;

  spi_engine_sdo_lane_scheduler #(.NUM_OF_SDO(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_mask(cfg_mask), .cfg_ready(cfg_ready),
    .s_data_valid(s_data_valid), .s_data(s_data), .s_data_ready(s_data_ready),
    .lane_we(lane_we), .lane_sel(lane_sel), .lane_data(lane_data),
    .set_ready(set_ready), .load_ack(load_ack),
    .num_active(num_active), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = scanning, 1 = filling, 2 = waiting for the load.
  int         m_mode = 0;
  int         m_scan_left = N;
  logic [7:0] m_mask = 8'h0F;
  int         m_list[$];
  int         m_num = 0;
  int         m_pos = 0;
  bit         m_we = 0;
  bit         m_set = 0;
  int         m_sel = 0;
  logic [7:0] m_data = 8'h00;
  int         wait_cycles = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus with comb checks before the edge and registered checks after.
  task automatic step(input bit rst, input bit cv, input logic [7:0] cm,
                      input bit dv, input logic [7:0] d, input bit ack, output bit took);
    bit e_cr, e_sdr, e_busy;
    @(negedge clk);
    reset = rst; cfg_valid = cv; cfg_mask = cm;
    s_data_valid = dv; s_data = d; load_ack = ack;
    #1;
    e_cr   = (m_mode == 1) && (m_pos == 0);
    e_sdr  = (m_mode == 1) && !(e_cr && cv);
    e_busy = !((m_mode == 1) && (m_pos == 0));
    if (!rst) begin
      chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, e_cr});
      chk("s_data_ready", {31'd0, s_data_ready}, {31'd0, e_sdr});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
    end
    m_we = 0;
    if (rst) begin
      m_mode = 0; m_scan_left = N; m_mask = 8'h0F; m_list.delete();
      m_num = 0; m_pos = 0; m_set = 0; m_sel = 0; m_data = 8'h00;
    end else if (m_mode == 0) begin
      m_scan_left--;
      if (m_scan_left == 0) begin
        m_list.delete();
        for (int i = 0; i < N; i++) if (m_mask[i]) m_list.push_back(i);
        if (m_list.size() == 0) m_list.push_back(0);
        m_num = m_list.size();
        m_pos = 0;
        m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (cv && e_cr) begin
        m_mask = cm & 8'h0F;
        m_scan_left = N;
        m_mode = 0;
      end else if (dv) begin
        m_we = 1; m_sel = m_list[m_pos]; m_data = d;
        m_pos++;
        if (m_pos == m_num) begin
          m_pos = 0; m_set = 1; m_mode = 2;
        end
      end
    end else begin
      if (ack) begin
        m_set = 0; m_mode = 1;
      end
    end
    took = m_we;
    @(posedge clk); #1;
    chk("lane_we", {31'd0, lane_we}, {31'd0, m_we});
    chk("lane_sel", {28'd0, lane_sel}, m_sel);
    chk("lane_data", {24'd0, lane_data}, {24'd0, m_data});
    chk("set_ready", {31'd0, set_ready}, {31'd0, m_set});
    chk("num_active", {28'd0, num_active}, m_num);
  endtask

  // Push a run of words starting at base; acknowledge each set after two wait cycles.
  task automatic feed(input int count, input logic [7:0] base, input bit fast_ack);
    int  idx = 0;
    bit  took;
    bit  ack;
    for (int c = 0; c < 40 * (count + 1); c++) begin
      if (idx == count && m_mode == 1) break;
      if (m_mode == 2) wait_cycles++; else wait_cycles = 0;
      ack = fast_ack ? 1'b1 : (m_mode == 2 && wait_cycles > 2);
      step(0, 0, 8'h00, idx < count, base + 8'(idx), ack, took);
      if (took) begin
        $display("word %0d data=%0h -> lane %0d", idx, m_data, m_sel);
        idx++;
      end
    end
    chk("feed_done", idx, count);
  endtask

  initial begin
    bit took;

    // Reset, then default mask: four words onto lanes 0..3.
    step(1, 0, 8'h00, 1, 8'hEE, 0, took);
    step(1, 0, 8'h00, 0, 8'h00, 0, took);
    chk("reset_busy", {31'd0, busy}, 32'd1);
    feed(4, 8'hA1, 0);

    // Two-lane mask 0x0A: lanes 1 and 3, two full sets.
    step(0, 1, 8'h0A, 0, 8'h00, 0, took);
    feed(4, 8'h11, 0);

    // Empty mask falls back to lane 0, one word per set.
    step(0, 1, 8'h00, 0, 8'h00, 0, took);
    feed(3, 8'h30, 0);

    // Config and data together at a boundary: config wins.
    step(0, 1, 8'h0A, 1, 8'h55, 0, took);
    chk("conflict_no_data", {31'd0, took}, 32'd0);
    feed(1, 8'h40, 0);
    // Mid-set: cfg refused, data accepted.
    step(0, 1, 8'h0F, 1, 8'h66, 0, took);
    chk("midset_data_taken", {31'd0, took}, 32'd1);
    feed(0, 8'h00, 0);

    // Upper mask bits ignored; ack held high for earliest acknowledge.
    step(0, 1, 8'hFF, 0, 8'h00, 0, took);
    feed(4, 8'h70, 1);

    // Reset after two words with data still valid, then a fresh set.
    feed(2, 8'h80, 0);
    step(1, 0, 8'h00, 1, 8'h99, 0, took);
    feed(4, 8'hC0, 0);

    // Random traffic with occasional reconfiguration and rare resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0),
           8'($urandom), ($urandom_range(0, 3) != 0), 8'($urandom),
           ($urandom_range(0, 2) == 0), took);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
